// File: rtl/sd_ram_responder_if.sv
// Block-level SD image bus between the floppy controller (requester) and
// sd_ram_responder, plus the byte memory port the responder drives.
// The responder uses the slave modport; the requester/memory side uses master.
interface sd_ram_responder_if #(
  parameter int ADDR_W = 20
) ();
  // requester side
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              mem_ack;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ack,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_dout
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ack,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_dout
  );
endinterface

// File: rtl/sd_ram_responder.sv
// sd_ram_responder: serves 512-byte sector reads/writes of the SD image
// interface from a disk image held in byte-wide RAM.
// Optional feature macro: SD_RAM_RESPONDER_READONLY_EN adds img_readonly,
// which suppresses memory writes while keeping the full write handshake.
module sd_ram_responder #(
  parameter int          ADDR_W   = 20,
  parameter int unsigned MEM_BASE = 0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              img_valid,
  input  logic [ADDR_W-1:0] img_size,
`ifdef SD_RAM_RESPONDER_READONLY_EN
  input  logic              img_readonly,
`endif
  sd_ram_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_MEM  = 3'd1,
    RD_PUT  = 3'd2,
    WR_ADDR = 3'd3,
    WR_GET  = 3'd4,
    WR_MEM  = 3'd5,
    DONE    = 3'd6
  } state_e;

  state_e            state_r, state_s;
  logic [31:0]       lba_r, lba_s;
  logic [8:0]        cnt_r, cnt_s;
  logic              inr_r, inr_s;
  logic              ro_r, ro_s;
  logic              wr_en_s;
  logic              ack_r, ack_s;
  logic [8:0]        buff_addr_r, buff_addr_s;
  logic [7:0]        buff_dout_r, buff_dout_s;
  logic              buff_wr_r, buff_wr_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              mem_rd_r, mem_rd_s;
  logic              mem_wr_r, mem_wr_s;
  logic [7:0]        mem_dout_r, mem_dout_s;

  // Image byte address; the sum is wide enough that it is only ever truncated.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [31:0] lba, input logic [8:0] idx);
    logic [41:0] sum;
    sum = 42'(MEM_BASE) + {1'b0, lba, idx};
    return sum[ADDR_W-1:0];
  endfunction

  // Sector fully inside the image; 42-bit math so lba near 2^32 cannot wrap.
  function automatic logic in_range(input logic valid, input logic [ADDR_W-1:0] size,
                                    input logic [31:0] lba);
    return valid && (({1'b0, lba, 9'd0} + 42'd512) <= 42'(size));
  endfunction

  // Write permission latched at accept: in range and, if supported, not read-only.
`ifdef SD_RAM_RESPONDER_READONLY_EN
  assign wr_en_s = inr_r & ~ro_r;
`else
  assign wr_en_s = inr_r;
`endif

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_s     = state_r;
    lba_s       = lba_r;
    cnt_s       = cnt_r;
    inr_s       = inr_r;
    ro_s        = ro_r;
    ack_s       = ack_r;
    buff_addr_s = buff_addr_r;
    buff_dout_s = buff_dout_r;
    buff_wr_s   = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_rd_s    = mem_rd_r;
    mem_wr_s    = mem_wr_r;
    mem_dout_s  = mem_dout_r;
    case (state_r)
      IDLE: begin
        if (bus.sd_rd || bus.sd_wr) begin
          lba_s = bus.sd_lba;
          cnt_s = 9'd0;
          inr_s = in_range(img_valid, img_size, bus.sd_lba);
`ifdef SD_RAM_RESPONDER_READONLY_EN
          ro_s  = img_readonly;
`else
          ro_s  = 1'b0;
`endif
          ack_s = 1'b1;
          if (bus.sd_rd) begin
            state_s    = RD_MEM;
            mem_rd_s   = in_range(img_valid, img_size, bus.sd_lba);
            mem_addr_s = byte_addr(bus.sd_lba, 9'd0);
          end else begin
            state_s     = WR_ADDR;
            buff_addr_s = 9'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_MEM: begin
        if (!inr_r) begin
          buff_dout_s = 8'hFF;
          buff_wr_s   = 1'b1;
          buff_addr_s = cnt_r;
          state_s     = RD_PUT;
        end else if (bus.mem_ack) begin
          buff_dout_s = bus.mem_din;
          mem_rd_s    = 1'b0;
          buff_wr_s   = 1'b1;
          buff_addr_s = cnt_r;
          state_s     = RD_PUT;
        end else begin
          mem_rd_s = 1'b1;
        end
      end
      RD_PUT: begin
        if (cnt_r == 9'd511) begin
          ack_s   = 1'b0;
          state_s = DONE;
        end else begin
          cnt_s      = cnt_r + 9'd1;
          mem_rd_s   = inr_r;
          mem_addr_s = byte_addr(lba_r, cnt_r + 9'd1);
          state_s    = RD_MEM;
        end
      end
      WR_ADDR: begin
        state_s = WR_GET;
      end
      WR_GET: begin
        mem_dout_s = bus.sd_buff_din;
        if (wr_en_s) begin
          mem_wr_s   = 1'b1;
          mem_addr_s = byte_addr(lba_r, cnt_r);
          state_s    = WR_MEM;
        end else if (cnt_r == 9'd511) begin
          ack_s   = 1'b0;
          state_s = DONE;
        end else begin
          cnt_s       = cnt_r + 9'd1;
          buff_addr_s = cnt_r + 9'd1;
          state_s     = WR_ADDR;
        end
      end
      WR_MEM: begin
        if (!bus.mem_ack) begin
          mem_wr_s = 1'b1;
        end else if (cnt_r == 9'd511) begin
          mem_wr_s = 1'b0;
          ack_s    = 1'b0;
          state_s  = DONE;
        end else begin
          mem_wr_s    = 1'b0;
          cnt_s       = cnt_r + 9'd1;
          buff_addr_s = cnt_r + 9'd1;
          state_s     = WR_ADDR;
        end
      end
      DONE: begin
        if (!bus.sd_rd && !bus.sd_wr) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s  = IDLE;
        ack_s    = 1'b0;
        mem_rd_s = 1'b0;
        mem_wr_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in progress.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r     <= IDLE;
      lba_r       <= 32'd0;
      cnt_r       <= 9'd0;
      inr_r       <= 1'b0;
      ro_r        <= 1'b0;
      ack_r       <= 1'b0;
      buff_addr_r <= 9'd0;
      buff_dout_r <= 8'd0;
      buff_wr_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_dout_r  <= 8'd0;
    end else begin
      state_r     <= state_s;
      lba_r       <= lba_s;
      cnt_r       <= cnt_s;
      inr_r       <= inr_s;
      ro_r        <= ro_s;
      ack_r       <= ack_s;
      buff_addr_r <= buff_addr_s;
      buff_dout_r <= buff_dout_s;
      buff_wr_r   <= buff_wr_s;
      mem_addr_r  <= mem_addr_s;
      mem_rd_r    <= mem_rd_s;
      mem_wr_r    <= mem_wr_s;
      mem_dout_r  <= mem_dout_s;
    end
  end

  assign bus.sd_ack       = ack_r;
  assign bus.sd_buff_addr = buff_addr_r;
  assign bus.sd_buff_dout = buff_dout_r;
  assign bus.sd_buff_wr   = buff_wr_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_rd       = mem_rd_r;
  assign bus.mem_wr       = mem_wr_r;
  assign bus.mem_dout     = mem_dout_r;

endmodule

// File: tb/tb_sd_ram_responder.sv
// Self-checking bench for sd_ram_responder: byte-RAM model with a one-cycle
// ack, requester buffer model, and a scoreboard of expected sector bytes.
module tb_sd_ram_responder;
  localparam int ADDR_W = 20;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              img_valid;
  logic [ADDR_W-1:0] img_size;
`ifdef SD_RAM_RESPONDER_READONLY_EN
  logic              img_readonly;
`endif

  sd_ram_responder_if #(.ADDR_W(ADDR_W)) bus ();

  sd_ram_responder #(.ADDR_W(ADDR_W), .MEM_BASE(0)) u_dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .img_valid (img_valid),
    .img_size  (img_size),
`ifdef SD_RAM_RESPONDER_READONLY_EN
    .img_readonly (img_readonly),
`endif
    .bus       (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  ram  [16384];
  logic [7:0]  wbuf [512];
  logic [16:0] exp_q [$];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          step_cnt = 0;
  logic        mon_en = 1'b0;
  logic        mon_wr = 1'b0;
  logic        ack_prev = 1'b0;
  logic [8:0]  last_addr = 9'd0;

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37) ^ (a >> 6) ^ 8'h3C);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // requester buffer: data for the addressed byte is always presented
  assign bus.sd_buff_din = wbuf[bus.sd_buff_addr];

  // byte RAM: ack one cycle after a request, one-cycle pulse
  always @(posedge clk_sys) begin
    if (bus.mem_ack) begin
      bus.mem_ack <= 1'b0;
    end else if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) begin
      bus.mem_ack <= 1'b1;
      bus.mem_din <= ram[bus.mem_addr[13:0]];
      if (bus.mem_wr === 1'b1) begin
        ram[bus.mem_addr[13:0]] <= bus.mem_dout;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // output monitor: read scoreboard, write address sequence, port exclusivity
  always @(negedge clk_sys) begin
    if (mon_en) begin
      check("rd_wr_exclusive", {31'd0, bus.mem_rd & bus.mem_wr}, 32'd0);
      if (bus.sd_buff_wr === 1'b1) begin
        check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("rd_addr", {23'd0, bus.sd_buff_addr}, {23'd0, e[16:8]});
          check("rd_data", {24'd0, bus.sd_buff_dout}, {24'd0, e[7:0]});
        end
      end
      if (mon_wr && bus.sd_ack === 1'b1 && (!ack_prev || bus.sd_buff_addr !== last_addr)) begin
        check("wr_step", {23'd0, bus.sd_buff_addr}, 32'(step_cnt));
        step_cnt++;
      end
      ack_prev  = bus.sd_ack;
      last_addr = bus.sd_buff_addr;
    end
  end

  task automatic push_read(input logic [31:0] lba, input logic inr);
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back({9'(i), inr ? pat(int'(lba) * 512 + i) : 8'hFF});
    end
  endtask

  task automatic wait_ack(input logic level, input int budget, input string tag);
    int n = 0;
    while (bus.sd_ack !== level && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, {31'd0, bus.sd_ack}, {31'd0, level});
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [31:0] lba, input int hold);
    rd_cnt = 0; wr_cnt = 0; step_cnt = 0;
    @(negedge clk_sys);
    bus.sd_lba = lba; bus.sd_rd = rd; bus.sd_wr = wr;
    wait_ack(1'b1, 10, "ack_rise");
    if (hold == 0) begin
      bus.sd_rd = 1'b0; bus.sd_wr = 1'b0;
    end
    wait_ack(1'b0, 4000, "ack_fall");
    if (hold > 0) begin
      repeat (hold) @(negedge clk_sys);
      check("no_reserve_ack", {31'd0, bus.sd_ack}, 32'd0);
      bus.sd_rd = 1'b0; bus.sd_wr = 1'b0;
    end
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},   {31'd0, bus.sd_ack},       32'd0);
    check({tag, "_baddr"}, {23'd0, bus.sd_buff_addr}, 32'd0);
    check({tag, "_bdout"}, {24'd0, bus.sd_buff_dout}, 32'd0);
    check({tag, "_bwr"},   {31'd0, bus.sd_buff_wr},   32'd0);
    check({tag, "_maddr"}, 32'(bus.mem_addr),         32'd0);
    check({tag, "_mrd"},   {31'd0, bus.mem_rd},       32'd0);
    check({tag, "_mwr"},   {31'd0, bus.mem_wr},       32'd0);
    check({tag, "_mdout"}, {24'd0, bus.mem_dout},     32'd0);
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) ram[a] = pat(a);
    for (int i = 0; i < 512; i++) wbuf[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1; img_valid = 1'b1; img_size = 20'h02000;
`ifdef SD_RAM_RESPONDER_READONLY_EN
    img_readonly = 1'b0;
`endif
    bus.sd_lba = 32'd0; bus.sd_rd = 1'b0; bus.sd_wr = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_din = 8'd0;
    repeat (3) @(negedge clk_sys);
    check_outputs_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk_sys);

    // in-range read, request held well past the end of the transfer
    push_read(32'd3, 1'b1);
    xfer(1'b1, 1'b0, 32'd3, 20);
    check("rd3_left", 32'(exp_q.size()), 32'd0);
    check("rd3_memrd", 32'(rd_cnt), 32'd512);
    check("rd3_memwr", 32'(wr_cnt), 32'd0);

    // in-range write of i^0x5A to sector 1
    mon_wr = 1'b1;
    xfer(1'b0, 1'b1, 32'd1, 0);
    mon_wr = 1'b0;
    check("wr1_steps", 32'(step_cnt), 32'd512);
    check("wr1_memwr", 32'(wr_cnt), 32'd512);
    check("wr1_memrd", 32'(rd_cnt), 32'd0);
    for (int i = 0; i < 512; i++) check("wr1_ram", {24'd0, ram[512 + i]}, {24'd0, 8'(i) ^ 8'h5A});

    // smaller image: last sector in range, next one out of range
    img_size = 20'h01000;
    push_read(32'd7, 1'b1);
    xfer(1'b1, 1'b0, 32'd7, 0);
    check("rd7_memrd", 32'(rd_cnt), 32'd512);
    push_read(32'd8, 1'b0);
    xfer(1'b1, 1'b0, 32'd8, 0);
    check("rd8_left", 32'(exp_q.size()), 32'd0);
    check("rd8_memrd", 32'(rd_cnt), 32'd0);
    mon_wr = 1'b1;
    xfer(1'b0, 1'b1, 32'h8000_0000, 0);
    mon_wr = 1'b0;
    check("wrhi_steps", 32'(step_cnt), 32'd512);
    check("wrhi_memwr", 32'(wr_cnt), 32'd0);

    // no image present
    img_size = 20'h02000; img_valid = 1'b0;
    push_read(32'd0, 1'b0);
    xfer(1'b1, 1'b0, 32'd0, 0);
    check("inv_memrd", 32'(rd_cnt), 32'd0);
    xfer(1'b0, 1'b1, 32'd0, 0);
    check("inv_memwr", 32'(wr_cnt), 32'd0);
    img_valid = 1'b1;

    // simultaneous read and write requests: read wins
    push_read(32'd2, 1'b1);
    xfer(1'b1, 1'b1, 32'd2, 0);
    check("both_left", 32'(exp_q.size()), 32'd0);
    check("both_memwr", 32'(wr_cnt), 32'd0);

    // reset while byte 200 of a read waits on memory
    push_read(32'd3, 1'b1);
    @(negedge clk_sys);
    bus.sd_lba = 32'd3; bus.sd_rd = 1'b1;
    begin
      int n = 0;
      while (!(bus.mem_rd === 1'b1 && bus.sd_buff_addr === 9'd199) && n < 2000) begin
        @(negedge clk_sys);
        n++;
      end
    end
    check("pre_reset_memrd", {31'd0, bus.mem_rd}, 32'd1);
    reset = 1'b1; bus.sd_rd = 1'b0;
    @(negedge clk_sys);
    check_outputs_zero("midreset");
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk_sys);
    push_read(32'd4, 1'b1);
    xfer(1'b1, 1'b0, 32'd4, 0);
    check("rd4_left", 32'(exp_q.size()), 32'd0);
    check("rd4_memrd", 32'(rd_cnt), 32'd512);

`ifdef SD_RAM_RESPONDER_READONLY_EN
    // read-only image: full handshake, memory untouched
    img_readonly = 1'b1;
    mon_wr = 1'b1;
    xfer(1'b0, 1'b1, 32'd0, 0);
    mon_wr = 1'b0;
    img_readonly = 1'b0;
    check("ro_steps", 32'(step_cnt), 32'd512);
    check("ro_memwr", 32'(wr_cnt), 32'd0);
    for (int i = 0; i < 512; i++) check("ro_ram", {24'd0, ram[i]}, {24'd0, pat(i)});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
